gpr_multiport: RTL and testbench
================================

# gpr_multiport

Parametrised general-purpose register file for the MIPS pipeline, with two asynchronous read ports, two synchronous write ports, write-to-read bypass, and a hardwired zero register. It replaces the single-write-port file between decode (reads) and writeback (writes). A sequential scrub engine clears the array one entry per cycle on request, so software-visible state can be wiped without asserting global reset.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W entries
- ZERO_REG, 1, 1 = entry 0 reads as 0 and ignores writes; 0 = entry 0 is an ordinary register

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  reset, synchronous, active-high
- we0  in  1  write enable, port 0
- wa0  in  ADDR_W  write address, port 0
- wd0  in  DATA_W  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- wa1  in  ADDR_W  write address, port 1
- wd1  in  DATA_W  write data, port 1
- ra0  in  ADDR_W  read address, port 0
- rd0  out  DATA_W  read data, port 0 (combinational)
- ra1  in  ADDR_W  read address, port 1
- rd1  out  DATA_W  read data, port 1 (combinational)
- clr_req  in  1  start sequential scrub (sampled in IDLE only)
- busy  out  1  scrub in progress
- clr_done  out  1  one-cycle pulse when scrub completes

## Operation
- Reset: every entry is 0, FSM is IDLE, busy=0, clr_done=0. The whole array clears in one edge. Entries are also 0 at time zero for simulation.
- Writes:
  - At the edge, entry[waN] <= wdN for each port with weN=1.
  - If both ports write the same address, port 1 wins.
  - If ZERO_REG=1, writes to address 0 are discarded.
- Reads:
  - rdN = entry[raN], combinationally.
  - If ZERO_REG=1 and raN=0, rdN=0 regardless of bypass.
- Bypass (see Configuration): a read returns the data being written this cycle when its address matches an active write. Port 1's data has priority over port 0's.
- Scrub FSM:
  - IDLE → SCRUB on clr_req=1. The pointer loads 0 and busy rises the next cycle.
  - In SCRUB, each cycle entry[ptr] <= 0 and ptr increments.
  - When ptr = 2**ADDR_W−1, that entry is cleared and the FSM returns to IDLE. busy falls and clr_done pulses high for exactly one cycle.
  - clr_req while busy=1 is ignored (not queued).
  - While busy=1, both write ports are ignored; reads stay functional and return current array contents (no bypass).
  - A write and clr_req in the same IDLE cycle: the write is performed, then the scrub clears it.

## Timing
- Read latency: 0 cycles (combinational from raN and array state, plus weN/waN/wdN when bypass is enabled).
- Write latency: 1 edge. Without bypass, data is readable on the cycle after we.
- Scrub duration: 2**ADDR_W cycles with busy=1 (32 at default). The clr_done pulse coincides with the first cycle of busy=0.
- Reset mid-scrub: at the reset edge the array is fully zeroed, the FSM goes to IDLE, busy=0, and clr_done is not pulsed.
- Reset has priority over writes and over clr_req in the same cycle.
- Outputs under reset: busy=0, clr_done=0, rd0/rd1 = 0 for any address (bypass is suppressed while reset=1).

## Configuration
- GPR_BYPASS_EN defined:
  - Write-to-read forwarding is compiled in.
  - A same-cycle read of an address being written returns the new data.
  - The decode stage needs no extra WB→ID forward.
- GPR_BYPASS_EN undefined:
  - rdN is purely entry[raN].
  - Same-cycle reads return the old value, and the pipeline must forward externally.
- All other behaviour is identical in both builds.

## Test plan
- Reset then read: assert reset 1 cycle; read addresses 0..31 → all 0; busy=0, clr_done=0.
- Dual write, same address: we0=we1=1, wa0=wa1=7, wd0=0x11111111, wd1=0x22222222 → next cycle rd0(ra0=7)=0x22222222.
- Zero register: write 0xDEADBEEF to address 0 with ZERO_REG=1 → rd0(ra0=0)=0. With ZERO_REG=0 → 0xDEADBEEF.
- Bypass: we0=1, wa0=9, wd0=0x0000ABCD, ra1=9 in the same cycle → with GPR_BYPASS_EN, rd1=0x0000ABCD that cycle. Without it, rd1 = old value (0), then 0x0000ABCD next cycle.
- Scrub:
  - Fill entries 1..31 with i*3, pulse clr_req → busy high for exactly 32 cycles; clr_done single pulse; all reads 0.
  - A write to address 5 during busy is lost.
  - A second clr_req during busy has no effect.
- Reset mid-scrub: reset on scrub cycle 10 → next cycle busy=0, all entries 0, no clr_done pulse; a subsequent write/read to address 3 behaves normally.

Source files
------------

// File: rtl/gpr_multiport.sv
// Multiport GPR file: 2 async read ports, 2 sync write ports (port 1 wins), optional zero register, sequential scrub.
// Define GPR_BYPASS_EN to compile in same-cycle write-to-read forwarding.
//
// state | meaning
// IDLE  | normal operation, writes accepted, clr_req sampled
// SCRUB | clearing entry[r_ptr] each cycle, writes ignored, busy=1
module gpr_multiport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we0,
  input  logic [ADDR_W-1:0] wa0,
  input  logic [DATA_W-1:0] wd0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] wa1,
  input  logic [DATA_W-1:0] wd1,
  input  logic [ADDR_W-1:0] ra0,
  output logic [DATA_W-1:0] rd0,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic              clr_req,
  output logic              busy,
  output logic              clr_done
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic {IDLE = 1'b0, SCRUB = 1'b1} state_t;

  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
  state_t            r_state = IDLE;
  logic [ADDR_W-1:0] r_ptr = '0;
  logic              r_busy = 1'b0;
  logic              r_clr_done = 1'b0;

  logic              w_wr0;
  logic              w_wr1;
  logic [ADDR_W-1:0] w_ra [2];
  logic [1:0][DATA_W-1:0] w_rd;

  // Address 0 is dropped at the write side so the array never holds a nonzero value there.
  assign w_wr0 = we0 && !(ZERO_REG != 0 && wa0 == '0);
  assign w_wr1 = we1 && !(ZERO_REG != 0 && wa1 == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_busy     <= 1'b0;
      r_clr_done <= 1'b0;
    end else begin
      r_clr_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_wr0) r_mem[wa0] <= wd0;
          if (w_wr1) r_mem[wa1] <= wd1;
          if (clr_req) begin
            r_state <= SCRUB;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
          end
        end
        SCRUB: begin
          r_mem[r_ptr] <= '0;
          r_ptr        <= r_ptr + 1'b1;
          if (&r_ptr) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_clr_done <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_ra[0] = ra0;
  assign w_ra[1] = ra1;

  always_comb begin
    w_rd = '0;
    for (int p = 0; p < 2; p++) begin
      w_rd[p] = r_mem[w_ra[p]];
`ifdef GPR_BYPASS_EN
      // Forwarding only while writes are actually accepted.
      if (!r_busy) begin
        if (we1 && wa1 == w_ra[p])      w_rd[p] = wd1;
        else if (we0 && wa0 == w_ra[p]) w_rd[p] = wd0;
      end
`endif
      if (reset || (ZERO_REG != 0 && w_ra[p] == '0)) w_rd[p] = '0;
    end
  end

  assign rd0      = w_rd[0];
  assign rd1      = w_rd[1];
  assign busy     = r_busy;
  assign clr_done = r_clr_done;

endmodule

// File: tb/tb_gpr_multiport.sv
// Directed self-checking bench for gpr_multiport (default params plus a ZERO_REG=0 instance).
module tb_gpr_multiport;

  logic        clk = 1'b0;
  logic        reset;
  logic        we0, we1, clr_req;
  logic [4:0]  wa0, wa1, ra0, ra1;
  logic [31:0] wd0, wd1;
  logic [31:0] rd0, rd1, nz_rd0, nz_rd1;
  logic        busy, clr_done, nz_busy, nz_clr_done;

  int n_chk  = 0;
  int n_pass = 0;
  int busy_cnt, done_cnt, done_cyc;

  gpr_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1)) u_dut (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .rd0(rd0), .ra1(ra1), .rd1(rd1),
    .clr_req(clr_req), .busy(busy), .clr_done(clr_done)
  );

  gpr_multiport #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0)) u_dut_nz (
    .clk(clk), .reset(reset),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .ra0(ra0), .rd0(nz_rd0), .ra1(ra1), .rd1(nz_rd1),
    .clr_req(clr_req), .busy(nz_busy), .clr_done(nz_clr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Called at a negedge; returns at the next negedge with the write committed.
  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    we0 = 1'b1; wa0 = a; wd0 = d;
    @(negedge clk);
    we0 = 1'b0;
  endtask

  initial begin
    reset = 1'b1; we0 = 0; we1 = 0; clr_req = 0;
    wa0 = 0; wa1 = 0; wd0 = 0; wd1 = 0; ra0 = 5; ra1 = 0;
    @(negedge clk);
    #1 chk("rd0_in_reset", rd0, 32'h0);
    reset = 1'b0;

    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a); ra1 = 5'(31 - a);
      #1;
      chk($sformatf("reset_rd0_%0d", a), rd0, 32'h0);
      chk($sformatf("reset_rd1_%0d", a), rd1, 32'h0);
    end
    chk("reset_busy", {31'h0, busy}, 32'h0);
    chk("reset_clr_done", {31'h0, clr_done}, 32'h0);
    @(negedge clk);

    // same-address dual write, port 1 wins
    we0 = 1; we1 = 1; wa0 = 7; wa1 = 7; wd0 = 32'h11111111; wd1 = 32'h22222222;
    @(negedge clk);
    we0 = 0; we1 = 0; ra0 = 7;
    #1 chk("dual_write_7", rd0, 32'h22222222);

    // zero register
    wr0(5'd0, 32'hDEADBEEF);
    ra0 = 0; ra1 = 0;
    #1;
    chk("zero_reg_rd0", rd0, 32'h0);
    chk("zero_reg_rd1", rd1, 32'h0);
    chk("nz_reg0_rd0", nz_rd0, 32'hDEADBEEF);
    chk("nz_reg0_rd1", nz_rd1, 32'hDEADBEEF);

    // bypass
    we0 = 1; wa0 = 9; wd0 = 32'h0000ABCD; ra1 = 9;
    #1;
`ifdef GPR_BYPASS_EN
    chk("bypass_same_cycle", rd1, 32'h0000ABCD);
    we1 = 1; wa1 = 9; wd1 = 32'h0000BEEF;
    #1 chk("bypass_port1_prio", rd1, 32'h0000BEEF);
`else
    chk("nobypass_same_cycle", rd1, 32'h0);
`endif
    @(negedge clk);
    we0 = 0; we1 = 0;
`ifdef GPR_BYPASS_EN
    #1 chk("bypass_next_cycle", rd1, 32'h0000BEEF);
`else
    #1 chk("nobypass_next_cycle", rd1, 32'h0000ABCD);
`endif

    // fill 1..31 with i*3
    for (int i = 1; i < 32; i++) wr0(5'(i), 32'(i * 3));
    ra0 = 31; ra1 = 1;
    #1;
    chk("fill_31", rd0, 32'd93);
    chk("fill_1", rd1, 32'd3);

    // scrub; a port-1 write in the clr_req cycle is performed then cleared
    clr_req = 1; we1 = 1; wa1 = 12; wd1 = 32'h00000ABC;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      clr_req = 0; we1 = 0; we0 = 0;
      if (busy) busy_cnt++;
      if (clr_done) begin done_cnt++; done_cyc = cyc; end
      if (cyc == 3) begin
        we0 = 1; wa0 = 31; wd0 = 32'h777; ra0 = 31;
        #1 chk("read_during_busy", rd0, 32'd93);
      end
      if (cyc == 10) clr_req = 1;
      if (cyc == 20) begin we0 = 1; wa0 = 5; wd0 = 32'h55; end
    end
    chk("scrub_busy_cycles", 32'(busy_cnt), 32'd32);
    chk("scrub_done_pulses", 32'(done_cnt), 32'd1);
    chk("scrub_done_cycle", 32'(done_cyc), 32'd33);
    chk("nz_busy_idle", {31'h0, nz_busy}, 32'h0);
    for (int a = 0; a < 32; a++) begin
      ra0 = 5'(a); ra1 = 5'(a);
      #1;
      chk($sformatf("scrub_rd0_%0d", a), rd0, 32'h0);
      chk($sformatf("scrub_nz_rd1_%0d", a), nz_rd1, 32'h0);
    end

    // reset mid-scrub
    wr0(5'd30, 32'h30);
    wr0(5'd25, 32'h25);
    clr_req = 1;
    @(negedge clk);
    clr_req = 0;
    for (int cyc = 2; cyc <= 10; cyc++) @(negedge clk);
    chk("busy_before_reset", {31'h0, busy}, 32'h1);
    reset = 1; ra0 = 30; ra1 = 25;
    #1 chk("rd0_forced_in_reset", rd0, 32'h0);
    @(negedge clk);
    reset = 0;
    #1;
    chk("midreset_busy", {31'h0, busy}, 32'h0);
    chk("midreset_rd0_30", rd0, 32'h0);
    chk("midreset_rd1_25", rd1, 32'h0);
    done_cnt = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      if (clr_done || nz_clr_done) done_cnt++;
      @(negedge clk);
    end
    chk("midreset_no_done", 32'(done_cnt), 32'd0);
    wr0(5'd3, 32'h00003333);
    ra0 = 3;
    #1 chk("post_reset_wr3", rd0, 32'h00003333);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
